// File: rtl/cic_decim_comb.sv
// cic_decim_comb: decimator and N-stage comb section of a CIC decimation filter.
// Keeps every R-th enabled sample from the integrator chain and runs it through N
// first-difference stages (delay 1) in W-bit wrapping arithmetic. The result is
// registered with a one-cycle valid strobe.
// Optional build macro CIC_COMB_ROUND_EN: round half up when dropping the W-OW LSBs
// instead of plain truncation.
module cic_decim_comb #(
    parameter int W  = 10,
    parameter int R  = 8,
    parameter int N  = 3,
    parameter int OW = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [W-1:0]  din,
    input  logic          din_en,
    input  logic          clr,
    output logic [OW-1:0] dout,
    output logic          dout_vld
);

    localparam int            PW      = (R > 1) ? $clog2(R) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(R - 1);

`ifdef CIC_COMB_ROUND_EN
    // Half an output LSB; zero when no bits are dropped.
    localparam logic [W-1:0] RND = (OW < W) ? (W'(1) << ((OW < W) ? (W - OW - 1) : 0))
                                            : {W{1'b0}};
`else
    localparam logic [W-1:0] RND = {W{1'b0}};
`endif

    logic [PW-1:0] r_phase;
    logic [W-1:0]  r_dly [N];
    logic [OW-1:0] r_dout;
    logic          r_vld;

    logic          w_dec_stb;
    logic [W-1:0]  w_stage_in [N];
    logic [W-1:0]  w_y;
    logic [W-1:0]  w_y_rnd;
    logic [OW-1:0] w_out;

    assign w_dec_stb = din_en && (r_phase == PH_LAST);

    // Comb chain: each stage subtracts its delayed input; stage inputs are kept
    // separately because the delay registers capture the input, not the output.
    always_comb begin
        logic [W-1:0] v;
        v = din;
        for (int k = 0; k < N; k++) begin
            w_stage_in[k] = v;
            v = v - r_dly[k];
        end
        w_y = v;
    end

    assign w_y_rnd = w_y + RND;
    assign w_out   = w_y_rnd[W-1:W-OW];

    // Decimation phase: counts enabled samples only, so din_en gaps never slip it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase <= '0;
        end else if (clr) begin
            r_phase <= '0;
        end else if (din_en) begin
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
        end
    end

    // Comb history: updated only on kept samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N; k++) r_dly[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < N; k++) r_dly[k] <= '0;
        end else if (w_dec_stb) begin
            for (int k = 0; k < N; k++) r_dly[k] <= w_stage_in[k];
        end
    end

    // Output register and one-cycle valid strobe; dout holds between strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout <= '0;
            r_vld  <= 1'b0;
        end else if (clr) begin
            r_dout <= '0;
            r_vld  <= 1'b0;
        end else if (w_dec_stb) begin
            r_dout <= w_out;
            r_vld  <= 1'b1;
        end else begin
            r_vld  <= 1'b0;
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_vld;

endmodule

// File: tb/tb_cic_decim_comb.sv
// Testbench for cic_decim_comb: a default instance (W=10,R=8,N=3,OW=10) and an
// auxiliary instance (W=10,R=1,N=1,OW=8) share the stimulus. Reference model
// expresses the comb output as an N-th finite difference of kept samples.
module tb_cic_decim_comb;

    localparam int W = 10;

`ifdef CIC_COMB_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_en = 1'b0;
    logic         clr = 1'b0;
    logic [9:0]   dout_a;
    logic         dout_vld_a;
    logic [7:0]   dout_b;
    logic         dout_vld_b;

    always #5 clk = ~clk;

    cic_decim_comb #(.W(10), .R(8), .N(3), .OW(10)) u_dut (
        .clk(clk), .rstn(rstn), .din(din), .din_en(din_en), .clr(clr),
        .dout(dout_a), .dout_vld(dout_vld_a)
    );

    cic_decim_comb #(.W(10), .R(1), .N(1), .OW(8)) u_aux (
        .clk(clk), .rstn(rstn), .din(din), .din_en(din_en), .clr(clr),
        .dout(dout_b), .dout_vld(dout_vld_b)
    );

    int errors = 0;
    int checks = 0;

    // Model state per instance: enabled-sample count, kept samples (newest at 0).
    int m_cnt  [2];
    int m_hist [2][8];
    int m_dout [2];
    bit m_vld  [2];

    typedef struct {
        int din;
        bit en;
        bit clr;
        int exp_dout;
        bit exp_vld;
    } vec_t;

    vec_t tbl [32];

    function automatic int sext(input int v, input int bits);
        int r;
        r = v & ((1 << bits) - 1);
        if (r >= (1 << (bits - 1))) r = r - (1 << bits);
        return r;
    endfunction

    // sum_j (-1)^j C(N,j) s[n-j], then wrap, optional round, drop LSBs.
    function automatic int comb_ref(input int m);
        int n, ow, y, c;
        n  = (m == 0) ? 3 : 1;
        ow = (m == 0) ? 10 : 8;
        y  = 0;
        c  = 1;
        for (int j = 0; j <= n; j++) begin
            y = y + (((j % 2) == 1) ? -c : c) * m_hist[m][j];
            c = c * (n - j) / (j + 1);
        end
        y = y & ((1 << W) - 1);
        if (ROUND && ow < W) y = (y + (1 << (W - ow - 1))) & ((1 << W) - 1);
        return sext(y >> (W - ow), ow);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_cnt[m]  = 0;
            m_dout[m] = 0;
            m_vld[m]  = 1'b0;
            for (int j = 0; j < 8; j++) m_hist[m][j] = 0;
        end
    endtask

    task automatic model_step(input int d, input bit en, input bit c);
        int r;
        for (int m = 0; m < 2; m++) begin
            r = (m == 0) ? 8 : 1;
            m_vld[m] = 1'b0;
            if (c) begin
                model_reset_one(m);
            end else if (en) begin
                m_cnt[m]++;
                if (m_cnt[m] == r) begin
                    m_cnt[m] = 0;
                    for (int j = 7; j > 0; j--) m_hist[m][j] = m_hist[m][j-1];
                    m_hist[m][0] = sext(d, W);
                    m_dout[m] = comb_ref(m);
                    m_vld[m]  = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset_one(input int m);
        m_cnt[m]  = 0;
        m_dout[m] = 0;
        m_vld[m]  = 1'b0;
        for (int j = 0; j < 8; j++) m_hist[m][j] = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, predict, sample 1 time unit after posedge.
    task automatic cycle(input int d, input bit en, input bit c);
        @(negedge clk);
        din    = d[W-1:0];
        din_en = en;
        clr    = c;
        model_step(d, en, c);
        @(posedge clk);
        #1;
        chk("dout_a",     sext(int'(dout_a), 10), m_dout[0]);
        chk("dout_vld_a", int'(dout_vld_a),       int'(m_vld[0]));
        chk("dout_b",     sext(int'(dout_b), 8),  m_dout[1]);
        chk("dout_vld_b", int'(dout_vld_b),       int'(m_vld[1]));
    endtask

    initial begin
        int dec_exp [4];
        int v, last;
        bit found;

        dec_exp = '{7, -6, -1, 0};
        for (int i = 0; i < 32; i++) begin
            tbl[i].din      = i;
            tbl[i].en       = 1'b1;
            tbl[i].clr      = 1'b0;
            tbl[i].exp_vld  = ((i % 8) == 7);
            tbl[i].exp_dout = (i < 7) ? 0 : dec_exp[(i - 7) / 8];
        end

        model_reset();
        #1;
        chk("reset_dout_a", int'(dout_a),     0);
        chk("reset_vld_a",  int'(dout_vld_a), 0);
        chk("reset_dout_b", int'(dout_b),     0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Ramp from reset, table-driven.
        for (int i = 0; i < 32; i++) begin
            cycle(tbl[i].din, tbl[i].en, tbl[i].clr);
            chk("ramp_dout", sext(int'(dout_a), 10), tbl[i].exp_dout);
            chk("ramp_vld",  int'(dout_vld_a),       int'(tbl[i].exp_vld));
        end

        // Ramp continued through the 511 -> -512 wrap.
        for (int i = 32; i < 1100; i++) cycle(i, 1'b1, 1'b0);
        chk("wrap_steady", sext(int'(dout_a), 10), 0);

        // clr mid-phase with din_en high in the same cycle.
        cycle(0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cycle(100 + k, 1'b1, 1'b0);
        cycle(200, 1'b1, 1'b1);
        chk("clr_vld", int'(dout_vld_a), 0);
        chk("clr_dout", int'(dout_a), 0);
        for (int k = 0; k < 8; k++) cycle(300 + k, 1'b1, 1'b0);
        chk("clr_first_vld", int'(dout_vld_a), 1);
        chk("clr_first_dout", sext(int'(dout_a), 10), 307);

        // Enable gaps: ramp on enabled cycles only.
        cycle(0, 1'b0, 1'b1);
        v = 0;
        last = -1;
        for (int k = 0; k < 100; k++) begin
            if ((k % 2) == 0) begin
                cycle(v, 1'b1, 1'b0);
                v++;
            end else begin
                cycle(int'($urandom_range(0, 1023)), 1'b0, 1'b0);
            end
            if (dout_vld_a) begin
                if (last >= 0) chk("gap_spacing", k - last, 16);
                last = k;
            end
        end

        // Rounding on the OW=8 instance.
        cycle(0, 1'b0, 1'b1);
        cycle(0, 1'b1, 1'b0);
        cycle(6, 1'b1, 1'b0);
        chk("round_pos", sext(int'(dout_b), 8), ROUND ? 2 : 1);
        cycle(0, 1'b0, 1'b1);
        cycle(0, 1'b1, 1'b0);
        cycle(-6, 1'b1, 1'b0);
        chk("round_neg", sext(int'(dout_b), 8), ROUND ? -1 : -2);

        // Randomised traffic.
        for (int k = 0; k < 600; k++)
            cycle(int'($urandom_range(0, 1023)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0));

        // Async reset while a valid strobe is showing.
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(k * 5, 1'b1, 1'b0);
            if (dout_vld_a) found = 1'b1;
        end
        chk("rst_find_vld", int'(found), 1);
        rstn   = 1'b0;
        din_en = 1'b0;
        #1;
        chk("rst_dout_a", int'(dout_a),     0);
        chk("rst_vld_a",  int'(dout_vld_a), 0);
        chk("rst_dout_b", int'(dout_b),     0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) cycle(k * 3, 1'b1, 1'b0);
        chk("rst_first_vld",  int'(dout_vld_a), 1);
        chk("rst_first_dout", sext(int'(dout_a), 10), 21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
